// File: rtl/cu_cacheline_pack.sv
// cu_cacheline_pack: packs SIZE_BITS elements big-endian into 1024-bit lines.
// Define CU_PACK_BYTE_ENABLE_EN to build the per-byte enable mask.
module cu_cacheline_pack #(
  parameter  int SIZE_BITS = 32,
  localparam int LINE_BITS = 1024,
  localparam int N         = LINE_BITS / SIZE_BITS,
  localparam int CNT_BITS  = $clog2(N) + 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 enabled,
  input  logic                 start,
  input  logic [63:0]          base_addr,
  input  logic                 element_valid,
  input  logic [0:SIZE_BITS-1] element_data,
  output logic                 element_ready,
  input  logic                 flush,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic [0:LINE_BITS-1] line_data,
  output logic [63:0]          line_addr,
  output logic [CNT_BITS-1:0]  line_real_size,
  output logic [0:127]         line_byte_enable,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [0:LINE_BITS-1] asm_q, asm_d, asm_n;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d, cnt_n;
  logic [31:0]          idx_q, idx_d;
  logic [63:0]          base_q, base_d;
  logic                 fpend_q, fpend_d;

  logic                 ov_q, ov_d;
  logic [0:LINE_BITS-1] od_q, od_d;
  logic [63:0]          oa_q, oa_d;
  logic [CNT_BITS-1:0]  os_q, os_d;

  logic acc, full, out_free, want, hand, go;

  // Assembly view including the element accepted this cycle
  always_comb begin
    acc   = element_valid && element_ready;
    cnt_n = cnt_q + CNT_BITS'(acc);
    asm_n = asm_q;
    for (int k = 0; k < N; k++) begin
      if (acc && cnt_q == CNT_BITS'(k)) begin
        asm_n[k*SIZE_BITS +: SIZE_BITS] = element_data;
      end
    end
    full     = cnt_n == CNT_BITS'(N);
    out_free = !ov_q || line_ready;
    want     = (state_q == S_FILL
                && (full || (flush && cnt_n != '0)))
               || state_q == S_WAIT;
    hand     = want && out_free;
    go       = start
               && (state_q == S_IDLE || state_q == S_DONE);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_FILL;
      end
      S_FILL: begin
        if (want) begin
          if (!hand)      state_d = S_WAIT;
          else if (flush) state_d = S_DRAIN;
          else            state_d = S_FILL;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_WAIT: begin
        if (hand) begin
          state_d = (fpend_q || flush) ? S_DRAIN
                                       : S_FILL;
        end
      end
      S_DRAIN: begin
        if (out_free) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!enabled) state_d = S_IDLE;
  end

  always_comb begin
    element_ready = (state_q == S_FILL)
                    && (cnt_q != CNT_BITS'(N));
    done          = state_q == S_DONE;
  end

  always_comb begin
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    base_d  = base_q;
    fpend_d = fpend_q;
    ov_d    = ov_q;
    od_d    = od_q;
    oa_d    = oa_q;
    os_d    = os_q;
    if (ov_q && line_ready) ov_d = 1'b0;
    if (go) begin
      base_d  = base_addr;
      idx_d   = '0;
      cnt_d   = '0;
      asm_d   = '0;
      fpend_d = 1'b0;
    end else if (hand) begin
      ov_d    = 1'b1;
      od_d    = asm_n;
      os_d    = cnt_n;
      oa_d    = base_q + {25'd0, idx_q, 7'd0};
      idx_d   = idx_q + 32'd1;
      cnt_d   = '0;
      asm_d   = '0;
      fpend_d = 1'b0;
    end else if (state_q == S_FILL) begin
      asm_d   = asm_n;
      cnt_d   = cnt_n;
      fpend_d = want && flush;
    end else if (state_q == S_WAIT) begin
      fpend_d = fpend_q || flush;
    end
    if (!enabled) begin
      asm_d   = '0;
      cnt_d   = '0;
      idx_d   = '0;
      base_d  = '0;
      fpend_d = 1'b0;
      ov_d    = 1'b0;
      od_d    = '0;
      oa_d    = '0;
      os_d    = '0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      asm_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      fpend_q <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oa_q    <= '0;
      os_q    <= '0;
    end else begin
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      fpend_q <= fpend_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oa_q    <= oa_d;
      os_q    <= os_d;
    end
  end

  assign line_valid     = ov_q;
  assign line_data      = od_q;
  assign line_addr      = oa_q;
  assign line_real_size = os_q;

`ifdef CU_PACK_BYTE_ENABLE_EN
  logic [0:127] be_q, be_d;

  always_comb begin
    be_d = be_q;
    if (hand) begin
      for (int b = 0; b < 128; b++) begin
        be_d[b] = b < int'(cnt_n) * (SIZE_BITS / 8);
      end
    end
    if (!enabled) be_d = '0;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      be_q <= '0;
    end else begin
      be_q <= be_d;
    end
  end

  assign line_byte_enable = be_q;
`else
  // Full mask whenever a line is presented; zero otherwise
  assign line_byte_enable = {128{ov_q}};
`endif

endmodule

// File: tb/tb_cu_cacheline_pack.sv
// tb_cu_cacheline_pack: vector table, directed corner cases and a random
// run, all checked against a queue-based line model.
`timescale 1ns/1ps
module tb_cu_cacheline_pack;
  localparam int SB = 32;
  localparam int N  = 1024 / SB;
  localparam int CB = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst, enabled, start, flush, line_ready;
  logic          element_valid;
  logic [63:0]   base_addr;
  logic [0:SB-1] element_data;
  logic          element_ready, line_valid, done;
  logic [0:1023] line_data;
  logic [63:0]   line_addr;
  logic [CB-1:0] line_real_size;
  logic [0:127]  line_byte_enable;

  always #5 clk = ~clk;

  cu_cacheline_pack #(.SIZE_BITS(SB)) dut (
    .clock            (clk),
    .rst              (rst),
    .enabled          (enabled),
    .start            (start),
    .base_addr        (base_addr),
    .element_valid    (element_valid),
    .element_data     (element_data),
    .element_ready    (element_ready),
    .flush            (flush),
    .line_valid       (line_valid),
    .line_ready       (line_ready),
    .line_data        (line_data),
    .line_addr        (line_addr),
    .line_real_size   (line_real_size),
    .line_byte_enable (line_byte_enable),
    .done             (done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [0:1023] data;
    logic [63:0]   addr;
    int            size;
  } line_t;

  typedef enum {P_IDLE, P_ACT, P_DRN, P_DONE} phase_e;

  line_t         expq[$];
  logic [0:SB-1] cur[$];
  phase_e        phase = P_IDLE;
  logic [63:0]   m_base = '0;
  int unsigned   m_idx = 0;
  bit            mon_on = 0;
  bit            rnd_rdy = 0;
  int            n_taken = 0;
  int            last_size = 0;
  logic [63:0]   last_addr = '0;

  task automatic check(input string nm, input bit ok, input string msg);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", nm, msg);
    end
  endtask

  function automatic logic [0:127] exp_mask(input int size);
    logic [0:127] m;
    m = '0;
`ifdef CU_PACK_BYTE_ENABLE_EN
    for (int b = 0; b < size * SB / 8; b++) m[b] = 1'b1;
`else
    if (size > 0) m = '1;
`endif
    return m;
  endfunction

  function automatic void push_line();
    line_t l;
    l.data = '0;
    foreach (cur[k]) l.data[k*SB +: SB] = cur[k];
    l.size = cur.size();
    l.addr = m_base + 64'(m_idx) * 64'd128;
    m_idx++;
    expq.push_back(l);
    cur.delete();
  endfunction

  function automatic void model_clear();
    expq.delete();
    cur.delete();
    phase = P_IDLE;
    m_idx = 0;
  endfunction

  function automatic string data_msg(input logic [0:1023] want);
    logic [0:1023] got;
    got = line_data;
    for (int k = 0; k < N; k++) begin
      if (got[k*SB +: SB] !== want[k*SB +: SB])
        return $sformatf("elem %0d got %h want %h",
                         k, got[k*SB +: SB], want[k*SB +: SB]);
    end
    return "same";
  endfunction

  // Model advances at negedge, predicting the coming posedge
  line_t hd;
  always @(negedge clk) begin
    bit rdy_e, vld_e, dn_e, take;
    int pend;
    if (mon_on) begin
      pend  = expq.size();
      rdy_e = (phase == P_ACT) && (pend < 2);
      vld_e = pend > 0;
      dn_e  = phase == P_DONE;
      check("ctrl",
            element_ready === rdy_e && line_valid === vld_e
            && done === dn_e,
            $sformatf("rdy/vld/done got %b%b%b want %b%b%b",
                      element_ready, line_valid, done,
                      rdy_e, vld_e, dn_e));
      if (vld_e && line_valid) begin
        hd = expq[0];
        check("line_addr", line_addr === hd.addr,
              $sformatf("got %h want %h", line_addr, hd.addr));
        check("line_size", int'(line_real_size) == hd.size,
              $sformatf("got %0d want %0d", line_real_size, hd.size));
        check("line_be", line_byte_enable === exp_mask(hd.size),
              $sformatf("got %h want %h",
                        line_byte_enable, exp_mask(hd.size)));
        check("line_data", line_data === hd.data, data_msg(hd.data));
      end
      if (!rst) begin
        if (!enabled) begin
          model_clear();
        end else begin
          take = vld_e && line_ready;
          if (take) begin
            n_taken++;
            last_size = int'(line_real_size);
            last_addr = line_addr;
            void'(expq.pop_front());
          end
          if (phase == P_ACT) begin
            if (element_valid && rdy_e) begin
              cur.push_back(element_data);
              if (cur.size() == N) push_line();
            end
            if (flush) begin
              if (cur.size() > 0) push_line();
              phase = P_DRN;
            end
          end else if (phase == P_DRN) begin
            if (expq.size() == 0) phase = P_DONE;
          end else if (start) begin
            phase  = P_ACT;
            m_base = base_addr;
            m_idx  = 0;
            cur.delete();
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) line_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_xfer(input logic [63:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit fl, input int vpct,
                        input int seed, output int cyc);
    int k;
    bit a;
    k = 0;
    cyc = 0;
    if (n == 0) begin
      flush = fl;
      tick();
      flush = 1'b0;
      return;
    end
    while (k < n && cyc < 5000) begin
      element_valid = ($urandom_range(0, 99) < vpct);
      element_data  = SB'(seed + k);
      a = element_valid && element_ready;
      flush = fl && a && (k == n - 1);
      tick();
      if (a) k++;
      cyc++;
    end
    element_valid = 1'b0;
    flush = 1'b0;
    check("stream_bound", k == n,
          $sformatf("accepted %0d want %0d", k, n));
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int c;
    c = 0;
    while (done !== 1'b1 && c < maxc) begin
      tick();
      c++;
    end
    check(nm, done === 1'b1,
          $sformatf("done got %b want 1 after %0d cycles", done, maxc));
  endtask

  typedef struct {
    logic [63:0] base;
    int          nel;
    int          exp_lines;
    int          exp_last;
    logic [63:0] exp_addr;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   cyc, acc_n;
    bit   a;

    vt[0] = '{64'h1000, 32, 1, 32, 64'h1000};
    vt[1] = '{64'h1000, 96, 3, 32, 64'h1100};
    vt[2] = '{64'h2000,  5, 1,  5, 64'h2000};
    vt[3] = '{64'h3000,  0, 0,  0, 64'h0};
    vt[4] = '{64'h4000, 40, 2,  8, 64'h4080};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FF80, 33, 2, 1, 64'h0};

    rst = 1'b1;
    enabled = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    line_ready = 1'b1;
    element_valid = 1'b0;
    element_data = '0;
    base_addr = '0;
    mon_on = 1'b1;
    #12;
    check("rst_ready", element_ready === 1'b0,
          $sformatf("got %b want 0", element_ready));
    check("rst_valid", line_valid === 1'b0,
          $sformatf("got %b want 0", line_valid));
    check("rst_done", done === 1'b0, $sformatf("got %b want 0", done));
    check("rst_addr", line_addr === 64'h0,
          $sformatf("got %h want 0", line_addr));
    check("rst_size", line_real_size === '0,
          $sformatf("got %0d want 0", line_real_size));
    check("rst_be", line_byte_enable === '0,
          $sformatf("got %h want 0", line_byte_enable));
    check("rst_data", line_data === '0, "line_data nonzero");
    tick();
    rst = 1'b0;
    tick();

    // Vector table, line_ready held high
    foreach (vt[i]) begin
      n_taken = 0;
      last_size = 0;
      last_addr = '0;
      start_xfer(vt[i].base);
      stream(vt[i].nel, 1'b1, 100, i * 256, cyc);
      if (vt[i].nel > 0)
        check($sformatf("v%0d_nobubble", i), cyc == vt[i].nel,
              $sformatf("cycles %0d want %0d", cyc, vt[i].nel));
      wait_done($sformatf("v%0d_done", i), 200);
      check($sformatf("v%0d_lines", i), n_taken == vt[i].exp_lines,
            $sformatf("got %0d want %0d", n_taken, vt[i].exp_lines));
      check($sformatf("v%0d_last_size", i), last_size == vt[i].exp_last,
            $sformatf("got %0d want %0d", last_size, vt[i].exp_last));
      check($sformatf("v%0d_last_addr", i), last_addr === vt[i].exp_addr,
            $sformatf("got %h want %h", last_addr, vt[i].exp_addr));
    end

    // First-line latency
    start_xfer(64'h1000);
    stream(31, 1'b0, 100, 0, cyc);
    element_valid = 1'b1;
    element_data = SB'(31);
    check("lat_pre", line_valid === 1'b0,
          $sformatf("got %b want 0", line_valid));
    tick();
    element_valid = 1'b0;
    check("lat_post", line_valid === 1'b1,
          $sformatf("got %b want 1", line_valid));
    check("lat_first", line_data[0:31] === 32'd0,
          $sformatf("got %h want 0", line_data[0:31]));
    check("lat_last", line_data[992:1023] === 32'd31,
          $sformatf("got %h want 1f", line_data[992:1023]));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done("lat_done", 20);

    // Back-pressure: two lines fill, then drain in order
    line_ready = 1'b0;
    n_taken = 0;
    start_xfer(64'h5000);
    acc_n = 0;
    for (int c = 0; c < 70; c++) begin
      element_valid = 1'b1;
      element_data = SB'(acc_n);
      a = element_ready;
      tick();
      if (a) acc_n++;
    end
    element_valid = 1'b0;
    check("bp_accepted", acc_n == 64,
          $sformatf("got %0d want 64", acc_n));
    check("bp_ready_low", element_ready === 1'b0,
          $sformatf("got %b want 0", element_ready));
    check("bp_hold_addr", line_addr === 64'h5000,
          $sformatf("got %h want 5000", line_addr));
    line_ready = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done("bp_done", 20);
    check("bp_lines", n_taken == 2, $sformatf("got %0d want 2", n_taken));

    // Flush arriving while a full line waits
    line_ready = 1'b0;
    n_taken = 0;
    start_xfer(64'h7000);
    stream(64, 1'b0, 100, 1000, cyc);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("wf_done_low", done === 1'b0, $sformatf("got %b want 0", done));
    line_ready = 1'b1;
    wait_done("wf_done", 10);
    check("wf_lines", n_taken == 2, $sformatf("got %0d want 2", n_taken));

    // Empty flush: done two edges after the flush edge
    n_taken = 0;
    start_xfer(64'h6000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ef_done_early", done === 1'b0, $sformatf("got %b want 0", done));
    tick();
    check("ef_done", done === 1'b1, $sformatf("got %b want 1", done));
    check("ef_lines", n_taken == 0, $sformatf("got %0d want 0", n_taken));

    // Reset mid-line discards the partial line
    start_xfer(64'h8000);
    stream(10, 1'b0, 100, 77, cyc);
    rst = 1'b1;
    model_clear();
    #1;
    check("mr_ready", element_ready === 1'b0,
          $sformatf("got %b want 0", element_ready));
    check("mr_valid", line_valid === 1'b0,
          $sformatf("got %b want 0", line_valid));
    check("mr_data", line_data === '0, "line_data nonzero");
    check("mr_addr", line_addr === 64'h0,
          $sformatf("got %h want 0", line_addr));
    check("mr_size", line_real_size === '0,
          $sformatf("got %0d want 0", line_real_size));
    check("mr_be", line_byte_enable === '0,
          $sformatf("got %h want 0", line_byte_enable));
    tick();
    rst = 1'b0;
    n_taken = 0;
    tick();
    start_xfer(64'h9000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done("mr_done", 10);
    check("mr_lines", n_taken == 0, $sformatf("got %0d want 0", n_taken));

    // Random traffic with random back-pressure and aborts
    rnd_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int n;
      logic [63:0] b;
      n = $urandom_range(0, 100);
      b = {$urandom(), $urandom()} & ~64'h7F;
      start_xfer(b);
      if ($urandom_range(0, 9) == 0) begin
        stream(n / 2, 1'b0, 70, $urandom(), cyc);
        enabled = 1'b0;
        tick();
        enabled = 1'b1;
        tick();
      end else begin
        stream(n, 1'b1, $urandom_range(40, 100), $urandom(), cyc);
        wait_done($sformatf("rnd%0d_done", t), 500);
      end
    end
    rnd_rdy = 1'b0;
    line_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
